// File: rtl/pipeline_ctrl_pkg.sv
// Shared types and constants for the MIPS pipeline hazard controller.
//   FWD_*       : operand source encodings driven on fwd_sel_rs/fwd_sel_rt
//   x_shadow_t  : destination tracking for the instruction in X
//   m_shadow_t  : destination tracking for the instruction in M
//   fwd_select  : per-operand forwarding source selection
package pipeline_ctrl_pkg;

    localparam logic [1:0] FWD_REGFILE = 2'b00;
    localparam logic [1:0] FWD_ALU     = 2'b01;
    localparam logic [1:0] FWD_MEM     = 2'b10;

    typedef struct packed {
        logic       valid;
        logic [4:0] addr;
        logic       is_load;
    } x_shadow_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] addr;
    } m_shadow_t;

    // A load in X has no result yet, so it can never feed the ALU path;
    // that case is caught by the load-use stall instead.
    function automatic logic [1:0] fwd_select(input logic       uses,
                                              input logic [4:0] addr,
                                              input x_shadow_t  x,
                                              input m_shadow_t  m);
        logic [1:0] sel;
        sel = FWD_REGFILE;
        if (uses && addr != 5'd0) begin
            if (x.valid && x.addr == addr && !x.is_load)
                sel = FWD_ALU;
            else if (m.valid && m.addr == addr)
                sel = FWD_MEM;
        end
        return sel;
    endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Decode-side bundle between the decode stage and the hazard controller.
//   master : decode stage (drives instruction info and dmem_ready, takes controls)
//   slave  : pipeline_ctrl
interface pipeline_ctrl_if;
    logic [4:0] id_rs_addr;
    logic [4:0] id_rt_addr;
    logic       id_uses_rs;
    logic       id_uses_rt;
    logic       id_reg_we;
    logic [4:0] id_reg_write_addr;
    logic       id_mem_read;
    logic       id_is_muldiv;
    logic       id_reads_hilo;
    logic       dmem_ready;
    logic [1:0] fwd_sel_rs;
    logic [1:0] fwd_sel_rt;
    logic       stall_fd;
    logic       bubble_x;
    logic       freeze_all;
    logic       muldiv_start;
    logic       muldiv_busy;

    modport master (
        output id_rs_addr, id_rt_addr, id_uses_rs, id_uses_rt, id_reg_we,
               id_reg_write_addr, id_mem_read, id_is_muldiv, id_reads_hilo,
               dmem_ready,
        input  fwd_sel_rs, fwd_sel_rt, stall_fd, bubble_x, freeze_all,
               muldiv_start, muldiv_busy
    );

    modport slave (
        input  id_rs_addr, id_rt_addr, id_uses_rs, id_uses_rt, id_reg_we,
               id_reg_write_addr, id_mem_read, id_is_muldiv, id_reads_hilo,
               dmem_ready,
        output fwd_sel_rs, fwd_sel_rt, stall_fd, bubble_x, freeze_all,
               muldiv_start, muldiv_busy
    );
endinterface

// File: rtl/pipeline_ctrl_muldiv_sequencer.sv
// IDLE/BUSY sequencer for the multi-cycle mult/div unit.
//   clk, rst_n : pipeline clock, async active-low reset
//   start      : 1-cycle start strobe (only honoured in IDLE)
//   busy       : unit occupied; stays high through the cnt==0 cycle
// The count runs every cycle regardless of pipeline freeze: the unit
// itself never stalls.
module muldiv_sequencer #(
    parameter int MULDIV_CYCLES = 32,
    parameter int CNT_W         = 6
) (
    input  logic clk,
    input  logic rst_n,
    input  logic start,
    output logic busy
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_BUSY = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_BUSY;
                    cnt_d   = CNT_W'(MULDIV_CYCLES - 1);
                end
            end
            default: begin
                if (cnt_q == '0)
                    state_d = S_IDLE;
                else
                    cnt_d = cnt_q - 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign busy = (state_q == S_BUSY);

endmodule

// File: rtl/pipeline_ctrl.sv
// Hazard/sequencing controller for the 5-stage MIPS pipeline.
//   clk, rst_n : pipeline clock, async active-low reset
//   ctl        : decode-side bundle (pipeline_ctrl_if.slave)
//                in : rs/rt fields and usage, destination, load/muldiv/hilo
//                     flags, dmem_ready
//                out: fwd_sel_rs/rt, stall_fd, bubble_x, freeze_all,
//                     muldiv_start, muldiv_busy
// Branch delay slots are architectural, so nothing here ever flushes.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int MULDIV_CYCLES = 32,
    parameter int CNT_W         = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    pipeline_ctrl_if.slave   ctl
);

    x_shadow_t x_q, x_d;
    m_shadow_t m_q, m_d;

    logic rs_hit_x, rt_hit_x, lu, md_hz;
    logic freeze, stall, start, busy;
    logic id_dst_valid;

    muldiv_sequencer #(
        .MULDIV_CYCLES (MULDIV_CYCLES),
        .CNT_W         (CNT_W)
    ) u_muldiv (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .busy  (busy)
    );

    // Outputs are gated with rst_n so the whole control bundle is quiet
    // while reset is asserted, independent of what decode presents.
    always_comb begin
        rs_hit_x = ctl.id_uses_rs && ctl.id_rs_addr != 5'd0 && ctl.id_rs_addr == x_q.addr;
        rt_hit_x = ctl.id_uses_rt && ctl.id_rt_addr != 5'd0 && ctl.id_rt_addr == x_q.addr;
        lu       = x_q.valid && x_q.is_load && (rs_hit_x || rt_hit_x);
        md_hz    = busy && (ctl.id_reads_hilo || ctl.id_is_muldiv);
        freeze   = rst_n && !ctl.dmem_ready;
        stall    = rst_n && !freeze && (lu || md_hz);
        start    = rst_n && ctl.id_is_muldiv && !busy && !lu && !freeze;
    end

    assign id_dst_valid = ctl.id_reg_we && ctl.id_reg_write_addr != 5'd0;

    always_comb begin
        x_d = x_q;
        m_d = m_q;
        if (!freeze) begin
            m_d = '{valid: x_q.valid, addr: x_q.addr};
            if (stall)
                x_d = '0;
            else
                x_d = '{valid:   id_dst_valid,
                        addr:    ctl.id_reg_write_addr,
                        is_load: id_dst_valid && ctl.id_mem_read};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q <= '0;
            m_q <= '0;
        end else begin
            x_q <= x_d;
            m_q <= m_d;
        end
    end

    assign ctl.fwd_sel_rs   = fwd_select(ctl.id_uses_rs, ctl.id_rs_addr, x_q, m_q);
    assign ctl.fwd_sel_rt   = fwd_select(ctl.id_uses_rt, ctl.id_rt_addr, x_q, m_q);
    assign ctl.stall_fd     = stall;
    assign ctl.bubble_x     = stall;
    assign ctl.freeze_all   = freeze;
    assign ctl.muldiv_start = start;
    assign ctl.muldiv_busy  = busy;

endmodule
